// File: rtl/pcileech_com_link_arb.sv
// pcileech_com_link_arb
// Arbitrates the shared 32-bit com RX/TX datapath between the FT601 and the
// UDP Ethernet transports in the clk_com domain. One transport owns the
// datapath at a time. Ownership is released after IDLE_TIMEOUT cycles of
// owner inactivity, or when cfg_force makes the owner ineligible. Release is
// held off while a TX FIFO read is requested or in flight, so no TX word is
// lost or misrouted. Non-owner RX words are dropped and counted.
module pcileech_com_link_arb #(
  parameter logic [31:0] IDLE_TIMEOUT = 32'd100_000_000,
  parameter logic        PRIO_ETH     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cfg_force,
  input  logic [31:0] ft_rx_data,
  input  logic        ft_rx_valid,
  input  logic        ft_din_req,
  output logic        ft_din_wr_en,
  input  logic [31:0] eth_rx_data,
  input  logic        eth_rx_valid,
  input  logic        eth_din_ready,
  output logic        eth_din_empty,
  output logic        eth_din_wr_en,
  output logic [31:0] com_rx_data32,
  output logic        com_rx_valid32,
  output logic        core_din_ready,
  input  logic        core_din_wr_en,
  input  logic        core_din_empty,
  output logic [1:0]  owner,
  output logic [15:0] drop_cnt
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_FT   = 2'b01;
  localparam logic [1:0] ST_ETH  = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rx_valid_q, rx_valid_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [15:0] drop_q, drop_d;

  logic ft_elig, eth_elig;
  logic ft_fwd, eth_fwd, drop_any;
  logic tx_busy, rel_want;

  // Next-state, RX steering, TX strobe routing and inactivity timer.
  always_comb begin
    ft_elig        = (cfg_force != 2'b10);
    eth_elig       = (cfg_force != 2'b01);
    state_d        = state_q;
    timer_d        = timer_q;
    ft_fwd         = 1'b0;
    eth_fwd        = 1'b0;
    tx_busy        = 1'b0;
    rel_want       = 1'b0;
    core_din_ready = 1'b0;
    ft_din_wr_en   = 1'b0;
    eth_din_wr_en  = 1'b0;
    eth_din_empty  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        timer_d = 32'd0;
        if (ft_rx_valid && ft_elig && eth_rx_valid && eth_elig) begin
          if (PRIO_ETH) begin
            eth_fwd = 1'b1;
            state_d = ST_ETH;
          end else begin
            ft_fwd  = 1'b1;
            state_d = ST_FT;
          end
        end else if (ft_rx_valid && ft_elig) begin
          ft_fwd  = 1'b1;
          state_d = ST_FT;
        end else if (eth_rx_valid && eth_elig) begin
          eth_fwd = 1'b1;
          state_d = ST_ETH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FT: begin
        ft_fwd         = ft_rx_valid && ft_elig;
        core_din_ready = ft_din_req;
        ft_din_wr_en   = core_din_wr_en;
        // A read requested this cycle would land after release; hold off.
        tx_busy        = rd_pend_q || core_din_wr_en || ft_din_req;
        rel_want       = (timer_q == IDLE_TIMEOUT) || !ft_elig;
        if (rel_want && !tx_busy) begin
          state_d = ST_IDLE;
          timer_d = 32'd0;
        end else if (ft_rx_valid || core_din_wr_en) begin
          timer_d = 32'd0;
        end else if (timer_q != IDLE_TIMEOUT) begin
          timer_d = timer_q + 32'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      ST_ETH: begin
        eth_fwd        = eth_rx_valid && eth_elig;
        core_din_ready = eth_din_ready;
        eth_din_wr_en  = core_din_wr_en;
        eth_din_empty  = core_din_empty;
        tx_busy        = rd_pend_q || core_din_wr_en || eth_din_ready;
        rel_want       = (timer_q == IDLE_TIMEOUT) || !eth_elig;
        if (rel_want && !tx_busy) begin
          state_d = ST_IDLE;
          timer_d = 32'd0;
        end else if (eth_rx_valid || core_din_wr_en) begin
          timer_d = 32'd0;
        end else if (timer_q != IDLE_TIMEOUT) begin
          timer_d = timer_q + 32'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = 32'd0;
      end
    endcase

    rd_pend_d  = core_din_ready;
    rx_valid_d = ft_fwd || eth_fwd;
    if (ft_fwd) begin
      rx_data_d = ft_rx_data;
    end else if (eth_fwd) begin
      rx_data_d = eth_rx_data;
    end else begin
      rx_data_d = rx_data_q;
    end

    // Several drops in one cycle count once; the counter sticks at all-ones.
    drop_any = (ft_rx_valid && !ft_fwd) || (eth_rx_valid && !eth_fwd);
    if (drop_any && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State, timer, read-in-flight flag, registered RX path and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= 32'd0;
      rd_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 32'd0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_pend_q  <= rd_pend_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      drop_q     <= drop_d;
    end
  end

  assign owner          = state_q;
  assign com_rx_valid32 = rx_valid_q;
  assign com_rx_data32  = rx_data_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_pcileech_com_link_arb.sv
// Scoreboard bench for pcileech_com_link_arb. dut0 (FT601 priority) carries
// most scenarios; dut1 (ETH priority) is used for the tie-break case.
module tb_pcileech_com_link_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_force;
  logic [31:0] ft_rx_data, eth_rx_data;
  logic        ft_rx_valid, eth_rx_valid;
  logic        ft_din_req, eth_din_ready;
  logic        core_din_wr_en, core_din_empty;
  logic        ft_din_wr_en, eth_din_empty, eth_din_wr_en;
  logic [31:0] com_rx_data32;
  logic        com_rx_valid32, core_din_ready;
  logic [1:0]  owner;
  logic [15:0] drop_cnt;

  logic [31:0] ft1_rx_data, eth1_rx_data;
  logic        ft1_rx_valid, eth1_rx_valid;
  logic        ft1_din_wr_en, eth1_din_empty, eth1_din_wr_en;
  logic [31:0] com1_rx_data32;
  logic        com1_rx_valid32, core1_din_ready;
  logic [1:0]  owner1;
  logic [15:0] drop1_cnt;

  int checks = 0;
  int errors = 0;
  int ft_pulses = 0;
  int eth_pulses = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  pcileech_com_link_arb #(.IDLE_TIMEOUT(32'd8), .PRIO_ETH(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cfg_force(cfg_force),
    .ft_rx_data(ft_rx_data), .ft_rx_valid(ft_rx_valid),
    .ft_din_req(ft_din_req), .ft_din_wr_en(ft_din_wr_en),
    .eth_rx_data(eth_rx_data), .eth_rx_valid(eth_rx_valid),
    .eth_din_ready(eth_din_ready), .eth_din_empty(eth_din_empty),
    .eth_din_wr_en(eth_din_wr_en),
    .com_rx_data32(com_rx_data32), .com_rx_valid32(com_rx_valid32),
    .core_din_ready(core_din_ready), .core_din_wr_en(core_din_wr_en),
    .core_din_empty(core_din_empty), .owner(owner), .drop_cnt(drop_cnt)
  );

  pcileech_com_link_arb #(.IDLE_TIMEOUT(32'd8), .PRIO_ETH(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cfg_force(cfg_force),
    .ft_rx_data(ft1_rx_data), .ft_rx_valid(ft1_rx_valid),
    .ft_din_req(1'b0), .ft_din_wr_en(ft1_din_wr_en),
    .eth_rx_data(eth1_rx_data), .eth_rx_valid(eth1_rx_valid),
    .eth_din_ready(1'b0), .eth_din_empty(eth1_din_empty),
    .eth_din_wr_en(eth1_din_wr_en),
    .com_rx_data32(com1_rx_data32), .com_rx_valid32(com1_rx_valid32),
    .core_din_ready(core1_din_ready), .core_din_wr_en(1'b0),
    .core_din_empty(1'b1), .owner(owner1), .drop_cnt(drop1_cnt)
  );

  // TX FIFO model: data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (rst) core_din_wr_en <= 1'b0;
    else     core_din_wr_en <= core_din_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // dut0 monitor: pops expected RX words, counts TX wr_en pulses.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (com_rx_valid32) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx0_unexpected: got %h expected no word at %0t", com_rx_data32, $time);
        end else begin
          chk("rx0_word", com_rx_data32, q0.pop_front());
        end
      end
      if (ft_din_wr_en)  ft_pulses++;
      if (eth_din_wr_en) eth_pulses++;
    end
  end

  // dut1 monitor.
  always begin
    @(posedge clk);
    #1;
    if (!rst && com1_rx_valid32) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx1_unexpected: got %h expected no word at %0t", com1_rx_data32, $time);
      end else begin
        chk("rx1_word", com1_rx_data32, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_owner(input logic [1:0] exp, input int max, input string name);
    int n;
    n = 0;
    while (owner !== exp && n < max) begin
      tick();
      n++;
    end
    chk(name, {30'd0, owner}, {30'd0, exp});
  endtask

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    rst = 1'b1; cfg_force = 2'b00;
    ft_rx_data = 32'd0; ft_rx_valid = 1'b0; ft_din_req = 1'b0;
    eth_rx_data = 32'd0; eth_rx_valid = 1'b0; eth_din_ready = 1'b0;
    core_din_empty = 1'b1;
    ft1_rx_data = 32'd0; ft1_rx_valid = 1'b0;
    eth1_rx_data = 32'd0; eth1_rx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_valid", {31'd0, com_rx_valid32}, 32'd0);
    chk("rst_data", com_rx_data32, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_ready", {31'd0, core_din_ready}, 32'd0);
    chk("rst_empty", {31'd0, eth_din_empty}, 32'd1);

    // Four FT601 words back to back claim the link.
    for (int i = 0; i < 4; i++) begin
      ft_rx_valid = 1'b1; ft_rx_data = words[i];
      q0.push_back(words[i]);
      tick();
      if (i == 0) begin
        chk("claim_owner_ft", {30'd0, owner}, 32'd1);
        chk("claim_latency", {31'd0, com_rx_valid32}, 32'd1);
      end
    end
    ft_rx_valid = 1'b0;

    // ETH traffic while FT601 owns: all dropped.
    for (int i = 0; i < 3; i++) begin
      eth_rx_valid = 1'b1; eth_rx_data = 32'hE0000000 + i;
      tick();
    end
    eth_rx_valid = 1'b0;
    tick();
    chk("nonowner_drop", {16'd0, drop_cnt}, 32'd3);
    chk("nonowner_owner", {30'd0, owner}, 32'd1);

    wait_owner(2'b00, 20, "ft_timeout_release");

    // Tie in IDLE on both priority variants.
    ft_rx_valid = 1'b1; ft_rx_data = 32'hAAAA0001;
    eth_rx_valid = 1'b1; eth_rx_data = 32'hBBBB0001;
    ft1_rx_valid = 1'b1; ft1_rx_data = 32'hAAAA0002;
    eth1_rx_valid = 1'b1; eth1_rx_data = 32'hBBBB0002;
    q0.push_back(32'hAAAA0001);
    q1.push_back(32'hBBBB0002);
    tick();
    ft_rx_valid = 1'b0; eth_rx_valid = 1'b0;
    ft1_rx_valid = 1'b0; eth1_rx_valid = 1'b0;
    chk("tie_owner_prio_ft", {30'd0, owner}, 32'd1);
    chk("tie_drop_prio_ft", {16'd0, drop_cnt}, 32'd4);
    chk("tie_owner_prio_eth", {30'd0, owner1}, 32'd2);
    chk("tie_drop_prio_eth", {16'd0, drop1_cnt}, 32'd1);

    wait_owner(2'b00, 20, "tie_release");

    // ETH claim, then exact inactivity timeout.
    eth_rx_valid = 1'b1; eth_rx_data = 32'hC0DE0001;
    q0.push_back(32'hC0DE0001);
    tick();
    eth_rx_valid = 1'b0;
    repeat (8) tick();
    chk("eth_hold_before_expiry", {30'd0, owner}, 32'd2);
    tick();
    chk("eth_timeout_release", {30'd0, owner}, 32'd0);

    // ETH claim, TX request in the expiry cycle defers release.
    ft_pulses = 0; eth_pulses = 0;
    eth_rx_valid = 1'b1; eth_rx_data = 32'hC0DE0002;
    q0.push_back(32'hC0DE0002);
    tick();
    eth_rx_valid = 1'b0;
    repeat (8) tick();
    eth_din_ready = 1'b1; core_din_empty = 1'b0;
    #1;
    chk("eth_empty_view", {31'd0, eth_din_empty}, 32'd0);
    chk("eth_rd_en", {31'd0, core_din_ready}, 32'd1);
    tick();
    eth_din_ready = 1'b0; core_din_empty = 1'b1;
    chk("defer_owner_a", {30'd0, owner}, 32'd2);
    tick();
    chk("defer_owner_b", {30'd0, owner}, 32'd2);
    wait_owner(2'b00, 20, "deferred_release");
    chk("defer_eth_pulses", eth_pulses, 32'd1);
    chk("defer_ft_pulses", ft_pulses, 32'd0);

    // FT601 owner, cfg_force switches to ETH only with a read in flight.
    ft_rx_valid = 1'b1; ft_rx_data = 32'h55555555;
    q0.push_back(32'h55555555);
    tick();
    ft_rx_valid = 1'b0;
    chk("force_pre_owner", {30'd0, owner}, 32'd1);
    ft_pulses = 0; eth_pulses = 0;
    ft_din_req = 1'b1; cfg_force = 2'b10;
    tick();
    ft_din_req = 1'b0;
    chk("force_guard_owner", {30'd0, owner}, 32'd1);
    wait_owner(2'b00, 3, "force_release");
    chk("force_ft_pulses", ft_pulses, 32'd1);
    chk("force_eth_pulses", eth_pulses, 32'd0);

    eth_rx_valid = 1'b1; eth_rx_data = 32'h66666666;
    q0.push_back(32'h66666666);
    tick();
    eth_rx_valid = 1'b0;
    chk("force_eth_claim", {30'd0, owner}, 32'd2);
    ft_rx_valid = 1'b1; ft_rx_data = 32'h77777777;
    tick();
    chk("force_ft_drop", {16'd0, drop_cnt}, 32'd5);
    repeat (65535) tick();
    chk("drop_saturate", {16'd0, drop_cnt}, 32'h0000FFFF);
    tick();
    ft_rx_valid = 1'b0;
    tick();
    chk("drop_hold", {16'd0, drop_cnt}, 32'h0000FFFF);

    repeat (3) tick();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcileech_com_link_arb.md
Name: pcileech_com_link_arb

Overview:
- Sits in pcileech_com in the clk_com domain, between the two transport cores (FT601 and UDP Ethernet) and the shared 32-bit com RX/TX datapath.
- Grants exclusive ownership of the shared datapath to one transport at a time.
- Muxes that transport's RX words onto the 32->64 packer and steers TX FIFO read/valid strobes to it only.
- Releases ownership after a configurable period of link inactivity; non-owner RX traffic is discarded and counted.

Parameters:
- IDLE_TIMEOUT, 32'd100_000_000: owner-inactivity cycles before release; legal range >= 2.
- PRIO_ETH, 1'b0: tie-break when both transports present RX in the same IDLE cycle; 0 = FT601 wins, 1 = ETH wins.

Ports:
- clk  in  1  clk_com; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_force  in  2  00 = auto, 01 = FT601 only, 10 = ETH only, 11 = treated as 00
- ft_rx_data  in  32  FT601 RX word
- ft_rx_valid  in  1  FT601 RX strobe
- ft_din_req  in  1  FT601 requests a TX word
- ft_din_wr_en  out  1  TX word valid to FT601
- eth_rx_data  in  32  ETH RX word
- eth_rx_valid  in  1  ETH RX strobe
- eth_din_ready  in  1  ETH requests a TX word
- eth_din_empty  out  1  TX-empty view presented to ETH
- eth_din_wr_en  out  1  TX word valid to ETH
- com_rx_data32  out  32  muxed RX word to the packer
- com_rx_valid32  out  1  muxed RX strobe
- core_din_ready  out  1  rd_en to TX FIFO
- core_din_wr_en  in  1  TX FIFO valid; arrives 1 cycle after rd_en
- core_din_empty  in  1  TX FIFO empty
- owner  out  2  00 = none, 01 = FT601, 10 = ETH
- drop_cnt  out  16  saturating count of discarded non-owner RX words

Behaviour:
- Reset values: state IDLE; owner = 0; com_rx_valid32 = 0; com_rx_data32 = 0; drop_cnt = 0; timer = 0; rd_pend = 0.
- States: IDLE, OWN_FT, OWN_ETH; owner encodes the state.
- IDLE -> OWN_FT when ft_rx_valid is seen and FT601 is eligible (cfg_force 00/01). The claiming word is forwarded.
- IDLE -> OWN_ETH likewise for ETH (cfg_force 00/10).
- Both valid and both eligible in IDLE: PRIO_ETH decides; the loser's word is dropped.
- An ineligible transport's RX is always dropped, in any state.
- RX path is registered, latency exactly 1 cycle:
  - com_rx_valid32 <= owner-side valid, or the claiming valid in IDLE.
  - com_rx_data32 <= the corresponding data, updated only when valid; holds otherwise.
- drop_cnt increments by 1 per cycle in which at least one RX valid is discarded; saturates at 16'hFFFF. Two drops in the same cycle count as 1.
- TX in IDLE:
  - core_din_ready = 0; ft_din_wr_en = 0; eth_din_wr_en = 0; eth_din_empty = 1.
- TX in OWN_x (all combinational):
  - core_din_ready = that transport's request.
  - x_din_wr_en = core_din_wr_en; the other transport's wr_en = 0.
  - eth_din_empty = core_din_empty in OWN_ETH, else 1.
- rd_pend register = core_din_ready of the previous cycle (FIFO read in flight).
- Timer, in OWN_x:
  - Clears to 0 on an owner RX valid or on core_din_wr_en; otherwise increments, saturating at IDLE_TIMEOUT.
- Release OWN_x -> IDLE only when all three hold: timer == IDLE_TIMEOUT, rd_pend = 0, core_din_wr_en = 0.
  - If either TX condition fails, release is deferred; no TX word may be lost or misrouted.
  - Timer is cleared on entry to IDLE.
- cfg_force change: if it makes the current owner ineligible, force release through the same rd_pend/wr_en guard, ignoring the timer.
- Simultaneous release and new claim: the cycle that returns to IDLE does not also claim. RX arriving that cycle from the old owner is forwarded; RX from the other transport is dropped.
- rst mid-transfer: next cycle is IDLE with all outputs at reset values. In-flight FIFO data is discarded; the FIFO is reset by the same rst.

Test Plan:
- Reset, then 4 FT601 RX words 0x11111111..0x44444444 on consecutive cycles:
  - owner = 01 from the first word's cycle +1.
  - com_rx_valid32 high 4 cycles, each word 1 cycle late, in order; drop_cnt = 0.
- Owner FT601, ETH sends 3 words: none appear on com_rx_*; drop_cnt = 3; owner stays 01.
- IDLE, ft_rx_valid and eth_rx_valid in the same cycle:
  - PRIO_ETH = 0: owner = 01, FT word forwarded, drop_cnt = 1.
  - PRIO_ETH = 1: owner = 10, ETH word forwarded, drop_cnt = 1.
- IDLE_TIMEOUT = 8, owner ETH, no activity for 8 cycles with eth_din_ready held low:
  - owner = 00 on the next cycle.
- IDLE_TIMEOUT = 8, eth_din_ready asserted in the expiry cycle:
  - release deferred until that word's eth_din_wr_en pulse completes.
  - ft_din_wr_en never pulses.
- Owner FT601, set cfg_force = 10:
  - owner -> 00 within 2 cycles of TX quiescence.
  - next ETH RX claims, owner = 10; FT601 RX thereafter increments drop_cnt; drop_cnt saturates at 0xFFFF.
